// File: rtl/blink_monitor.sv
// blink_monitor: measures half-periods of a blinking line, reports lock and stuck status.
// Define BLINK_MON_SYNC_EN to add a two-flop synchronizer ahead of the sampling stage.
module blink_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXPECTED   = 51,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             light,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stuck,
    output logic             err
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STUCK} state_t;
    state_t           state_q, state_d;
    logic             ls_q, ld_q, tog, in_tol, tmo;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, period_q, period_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic             pv_q, pv_d, err_q, err_d;
`ifdef BLINK_MON_SYNC_EN
    logic s1_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            ls_q <= 1'b0;
        end else begin
            s1_q <= light;
            ls_q <= s1_q;
        end
    end
`else
    always_ff @(posedge clk) ls_q <= rst_n ? light : 1'b0;
`endif
    assign tog       = ls_q ^ ld_q;
    assign in_tol    = run_cnt_q >= CNT_W'(EXPECTED - TOL) && run_cnt_q <= CNT_W'(EXPECTED + TOL);
    assign tmo       = run_cnt_q == CNT_W'(TIMEOUT);
    assign match_inc = match_q == MW'(LOCK_COUNT) ? match_q : match_q + 1'b1;
    assign run_cnt_d = tog ? CNT_W'(1) : (&run_cnt_q ? run_cnt_q : run_cnt_q + 1'b1);
    // An edge always takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        match_d  = match_q;
        pv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: state_d = tog ? MEASURE : (tmo ? STUCK : IDLE);
            MEASURE: begin
                if (tog) begin
                    period_d = run_cnt_q;
                    pv_d     = 1'b1;
                    match_d  = in_tol ? match_inc : '0;
                    state_d  = in_tol && match_inc == MW'(LOCK_COUNT) ? LOCKED : MEASURE;
                end else if (tmo) begin
                    state_d = STUCK;
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (tog) begin
                    period_d = run_cnt_q;
                    pv_d     = 1'b1;
                    if (!in_tol) begin
                        state_d = MEASURE;
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = STUCK;
                    match_d = '0;
                end
            end
            default: begin
                if (tog) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_q      <= 1'b0;
            run_cnt_q <= '0;
            period_q  <= '0;
            match_q   <= '0;
            pv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_q      <= ls_q;
            run_cnt_q <= run_cnt_d;
            period_q  <= period_d;
            match_q   <= match_d;
            pv_q      <= pv_d;
            err_q     <= err_d;
        end
    end
    assign period       = period_q;
    assign period_valid = pv_q;
    assign err          = err_q;
    assign locked       = state_q == LOCKED;
    assign stuck        = state_q == STUCK;
endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed stimulus for blink_monitor with hand-computed expectations.
module tb_blink_monitor;
    localparam int TIMEOUT = 1024;
`ifdef BLINK_MON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, light = 1'b0;
    logic [15:0] period;
    logic        period_valid, locked, stuck, err;
    int          n_tests = 0, n_fail = 0, pv_cnt = 0, err_cnt = 0;

    blink_monitor dut (
        .clk(clk), .rst_n(rst_n), .light(light), .period(period),
        .period_valid(period_valid), .locked(locked), .stuck(stuck), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid) pv_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Toggle light, then hold it for n cycles; n is the next measured half-period.
    task automatic half(input int n);
        light = ~light;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_stuck", stuck, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        half(51);
        check("prime_no_pv", pv_cnt, 0);
        repeat (3) half(51);
        check("three_meas_pv", pv_cnt, 3);
        check("three_meas_unlocked", locked, 0);
        half(60);
        check("lock_period", period, 51);
        check("lock_pv", pv_cnt, 4);
        check("lock_locked", locked, 1);
        check("lock_no_err", err_cnt, 0);
        half(51);
        check("bad60_period", period, 60);
        check("bad60_err", err_cnt, 1);
        check("bad60_unlocked", locked, 0);
        repeat (3) half(51);
        check("relock3_unlocked", locked, 0);
        half(49);
        check("relock_locked", locked, 1);
        check("relock_period", period, 51);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_period", period, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_pv", period_valid, 0);
        check("mid_rst_stuck", stuck, 0);
        rst_n = 1'b1;
        pv_cnt = 0;
        half(49);
        check("rst_prime_no_pv", pv_cnt, 0);
        half(53);
        half(49);
        half(48);
        check("alt_3_unlocked", locked, 0);
        check("alt_3_period", period, 49);
        half(53);
        check("p48_period", period, 48);
        check("p48_no_err", err_cnt, 1);
        check("p48_unlocked", locked, 0);
        half(49);
        half(53);
        half(49);
        check("alt_restart_unlocked", locked, 0);
        half(51);
        check("alt_locked", locked, 1);
        check("alt_period", period, 49);
        check("alt_no_err", err_cnt, 1);
        half(TIMEOUT + LAT - 1);
        check("pre_stuck_stuck", stuck, 0);
        check("pre_stuck_locked", locked, 1);
        @(negedge clk);
        check("stuck_stuck", stuck, 1);
        check("stuck_locked", locked, 0);
        pv_cnt = 0;
        half(51);
        check("unstuck_stuck", stuck, 0);
        check("unstuck_no_pv", pv_cnt, 0);
        half(51);
        check("after_stuck_period", period, 51);
        check("after_stuck_pv", pv_cnt, 1);
        half(LAT - 1);
        check("lat_pre_pv", period_valid, 0);
        @(negedge clk);
        check("lat_pv", period_valid, 1);
        check("lat_period", period, 51);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
